// File: rtl/key_entry.sv
// Keypad event decoder: debounces the scanner's level-held key code into one
// event per press and maintains a BCD digit-entry buffer with a valid/ready hand-off.
module key_entry #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int LEN_W         = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  enable,
  input  logic [4:0]            key,
  output logic [4*DIGITS-1:0]   buf_digits,
  output logic [LEN_W-1:0]      buf_len,
  output logic                  entry_valid,
  input  logic                  entry_ready,
  output logic [4*DIGITS-1:0]   entry_data,
  output logic [LEN_W-1:0]      entry_len,
  output logic                  fn_valid,
  output logic [1:0]            fn_code,
  output logic                  key_err
);

  localparam int              CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DIGITS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  typedef enum logic [1:0] {K_DIGIT, K_FN, K_BS, K_ENTER} kind_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       code;
  logic             key_valid;
  logic             accept;
  kind_t            kind;
  logic [3:0]       digit;
  logic [1:0]       fn;

  // Valid/ready: entry_valid stays high with entry_data/entry_len frozen until
  // an edge that samples entry_ready=1 while entry_valid is already high.

  assign key_valid = (key != 5'd0) && (key <= 5'd16);
  assign accept    = (state == DEBOUNCE) && key_valid && (key == code) && (cnt == CNT_MAX);

  // Keypad layout: three digit columns per row, column 4 = A..D, bottom row *,0,#,D.
  always_comb begin
    kind  = K_DIGIT;
    digit = 4'h0;
    fn    = 2'd0;
    case (code)
      5'd1, 5'd2, 5'd3:     digit = code[3:0];
      5'd5, 5'd6, 5'd7:     digit = code[3:0] - 4'd1;
      5'd9, 5'd10, 5'd11:   digit = code[3:0] - 4'd2;
      5'd14:                digit = 4'h0;
      5'd4, 5'd8, 5'd12, 5'd16: begin
        kind = K_FN;
        fn   = code[3:2] - 2'd1;
      end
      5'd13:                kind = K_BS;
      5'd15:                kind = K_ENTER;
      default:              kind = K_DIGIT;
    endcase
  end

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= 5'd0;
    end else begin
      case (state)
        IDLE: if (key_valid) begin
          code  <= key;
          cnt   <= '0;
          state <= DEBOUNCE;
        end
        DEBOUNCE: begin
          if (!key_valid) begin
            state <= IDLE;
          end else if (key != code) begin
            code <= key;
            cnt  <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: if (!key_valid) begin
          cnt   <= '0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (key_valid) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      buf_digits  <= '0;
      buf_len     <= '0;
      entry_valid <= 1'b0;
      entry_data  <= '0;
      entry_len   <= '0;
      fn_valid    <= 1'b0;
      fn_code     <= 2'd0;
      key_err     <= 1'b0;
    end else begin
      fn_valid <= 1'b0;
      key_err  <= 1'b0;
      if (entry_valid && entry_ready) entry_valid <= 1'b0;
      if (accept) begin
        case (kind)
          K_DIGIT: begin
            if (buf_len < LEN_MAX) begin
              buf_digits <= {buf_digits[4*DIGITS-5:0], digit};
              buf_len    <= buf_len + 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end
          K_BS: begin
            if (buf_len != '0) begin
              buf_digits <= {4'h0, buf_digits[4*DIGITS-1:4]};
              buf_len    <= buf_len - 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end
          K_ENTER: begin
            if ((buf_len != '0) && !entry_valid) begin
              entry_data  <= buf_digits;
              entry_len   <= buf_len;
              entry_valid <= 1'b1;
              buf_digits  <= '0;
              buf_len     <= '0;
            end else begin
              key_err <= 1'b1;
            end
          end
          K_FN: begin
            fn_valid <= 1'b1;
            fn_code  <= fn;
          end
          default: key_err <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed keypad scenarios plus randomized presses with
// bounces, compared against a digit-list model of the entry buffer.
module tb_key_entry;

  localparam int DIGITS = 4;
  localparam int SC     = 4;
  localparam int LEN_W  = 3;
  localparam int W      = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             enable = 1'b0;
  logic [4:0]       key = 5'd0;
  logic             entry_ready = 1'b0;
  logic [W-1:0]     buf_digits;
  logic [LEN_W-1:0] buf_len;
  logic             entry_valid;
  logic [W-1:0]     entry_data;
  logic [LEN_W-1:0] entry_len;
  logic             fn_valid;
  logic [1:0]       fn_code;
  logic             key_err;

  key_entry #(.DIGITS(DIGITS), .STABLE_CYCLES(SC), .LEN_W(LEN_W)) dut (
    .clk(clk), .enable(enable), .key(key),
    .buf_digits(buf_digits), .buf_len(buf_len),
    .entry_valid(entry_valid), .entry_ready(entry_ready),
    .entry_data(entry_data), .entry_len(entry_len),
    .fn_valid(fn_valid), .fn_code(fn_code), .key_err(key_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0..9 digit, 10..13 fn A..D, 14 backspace, 15 enter; index = code-1.
  int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int           mq[$];
  bit           m_ev;
  logic [W-1:0] m_ed;
  int           m_el;
  int           m_fc;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack();
    logic [W-1:0] v;
    v = '0;
    foreach (mq[i]) v = {v[W-5:0], 4'(mq[i])};
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ev = 0;
    m_ed = '0;
    m_el = 0;
    m_fc = 0;
    exp_q.delete();
  endtask

  task automatic apply(input int c, output bit e_err, output bit e_fn);
    int m;
    m = keymap[c-1];
    e_err = 0;
    e_fn  = 0;
    if (m <= 9) begin
      if (mq.size() < DIGITS) mq.push_back(m);
      else e_err = 1;
    end else if (m <= 13) begin
      e_fn = 1;
      m_fc = m - 10;
    end else if (m == 14) begin
      if (mq.size() > 0) mq.delete(mq.size() - 1);
      else e_err = 1;
    end else begin
      if (mq.size() > 0 && !m_ev) begin
        m_ed = pack();
        m_el = mq.size();
        m_ev = 1;
        exp_q.push_back(m_ed);
        mq.delete();
      end else begin
        e_err = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_buf"}, buf_digits, pack());
    check({tag, "_len"}, buf_len, mq.size());
    check({tag, "_ev"}, entry_valid, m_ev);
    check({tag, "_ed"}, entry_data, m_ed);
    check({tag, "_el"}, entry_len, m_el);
    check({tag, "_fc"}, fn_code, m_fc);
  endtask

  // driver tasks: inputs change and outputs are sampled just after the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  function automatic int alt_code(input int c);
    return (c % 16) + 1;
  endfunction

  function automatic logic [4:0] none_code();
    return ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
  endfunction

  task automatic do_reset();
    enable = 1'b0;
    key = 5'd0;
    entry_ready = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    check("rst_fnv", fn_valid, 0);
    check("rst_err", key_err, 0);
    step();
    enable = 1'b1;
    step();
  endtask

  // Code is applied at this falling edge; accept is due SC rising edges after the next one.
  task automatic accept_phase(input int c, input int hold, input int rel,
                              input bit hold_alt, input bit rel_blip);
    bit e_err, e_fn;
    key = 5'(c);
    repeat (SC) step();
    check("pre_err", key_err, 0);
    check("pre_fnv", fn_valid, 0);
    check("pre_buf", buf_digits, pack());
    step();
    apply(c, e_err, e_fn);
    check_all("acc");
    check("acc_err", key_err, e_err);
    check("acc_fnv", fn_valid, e_fn);
    step();
    check("pulse_err", key_err, 0);
    check("pulse_fnv", fn_valid, 0);
    if (hold_alt) key = 5'(alt_code(c));
    repeat (hold) step();
    key = none_code();
    if (rel_blip) begin
      repeat (2) step();
      key = 5'(c);
      step();
      key = none_code();
    end
    repeat (rel) step();
    check_all("rel");
    check("rel_err", key_err, 0);
  endtask

  task automatic press_full(input int c, input int glitch, input int hold, input int rel,
                            input bit hold_alt, input bit rel_blip);
    if (glitch != 0) begin
      key = 5'(alt_code(c));
      repeat ($urandom_range(1, SC - 1)) step();
      if (glitch == 2) begin
        key = none_code();
        step();
      end
    end
    accept_phase(c, hold, rel, hold_alt, rel_blip);
  endtask

  task automatic press(input int c);
    press_full(c, 0, 1, SC + 1, 1'b0, 1'b0);
  endtask

  task automatic handshake();
    logic [W-1:0] want;
    want = exp_q.pop_front();
    check("hs_data", entry_data, want);
    entry_ready = 1'b1;
    step();
    entry_ready = 1'b0;
    m_ev = 0;
    check("hs_valid", entry_valid, 0);
    check_all("hs");
  endtask

  initial begin
    bit e_err, e_fn;
    int c;
    model_reset();
    repeat (2) step();
    check_all("reset");
    check("reset_fnv", fn_valid, 0);
    check("reset_err", key_err, 0);
    enable = 1'b1;
    step();

    // code 2 held 10 cycles, released 10 cycles
    accept_phase(2, 4, 10, 1'b0, 1'b0);
    check("t1_buf", buf_digits, 16'h0002);
    check("t1_len", buf_len, 1);
    do_reset();

    // bounce: 6 for 2 cycles, gap, then 6 held
    key = 5'd6;
    repeat (2) step();
    key = 5'd0;
    step();
    accept_phase(6, 2, SC + 1, 1'b0, 1'b0);
    check("t2_buf", buf_digits, 16'h0005);
    check("t2_len", buf_len, 1);
    do_reset();

    // fill buffer, overflow, backspace
    press(1); press(2); press(3); press(5);
    press(9);
    check("t3_buf", buf_digits, 16'h1234);
    check("t3_len", buf_len, 4);
    press(13);
    check("t3_bs_buf", buf_digits, 16'h0123);
    check("t3_bs_len", buf_len, 3);
    do_reset();

    // enter, rejected second enter, hand-off
    press(1); press(2); press(15);
    check("t4_ev", entry_valid, 1);
    check("t4_ed", entry_data, 16'h0012);
    check("t4_el", entry_len, 2);
    check("t4_buf", buf_digits, 16'h0000);
    press(15);
    check("t4_ed2", entry_data, 16'h0012);
    handshake();

    // enter with entry_ready already high: valid still lasts one cycle
    press(7);
    entry_ready = 1'b1;
    key = 5'd15;
    repeat (SC + 1) step();
    apply(15, e_err, e_fn);
    check("t5_rise", entry_valid, 1);
    check("t5_ed", entry_data, 16'h0006);
    step();
    m_ev = 0;
    void'(exp_q.pop_front());
    check("t5_fall", entry_valid, 0);
    entry_ready = 1'b0;
    key = 5'd0;
    repeat (SC + 1) step();
    check_all("t5");

    // function keys and backspace on empty buffer
    press(4);
    check("t6_fc_a", fn_code, 0);
    press(16);
    check("t6_fc_d", fn_code, 3);
    check("t6_len", buf_len, 0);
    press(13);

    // reset mid-debounce with an entry pending, key held through release
    press(1); press(15);
    check("t7_ev", entry_valid, 1);
    key = 5'd5;
    repeat (2) step();
    enable = 1'b0;
    key = 5'd14;
    #1;
    model_reset();
    check_all("t7_rst");
    check("t7_fnv", fn_valid, 0);
    check("t7_err", key_err, 0);
    step();
    enable = 1'b1;
    accept_phase(14, 1, SC + 1, 1'b0, 1'b0);
    check("t7_buf", buf_digits, 16'h0000);
    check("t7_len", buf_len, 1);

    // randomized presses
    repeat (80) begin
      if (m_ev && $urandom_range(0, 2) == 0) handshake();
      c = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(1, 16);
      press_full(c, $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(SC + 1, SC + 4),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    if (m_ev) handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_entry.md
# key_entry

Keypad event decoder and digit-entry buffer sitting directly downstream of the 4x4 keypad scanner. Consumes the scanner's level-held 5-bit key code (0 = none, 1..16 = key) and debounces it into one event per physical press. Maps each event to a decimal digit, backspace, enter or function key. Maintains a shift-in BCD entry buffer and hands completed entries to the application FSM over a valid/ready handshake.

## Interface
- `DIGITS`, 4: buffer depth in BCD digits.
- `STABLE_CYCLES`, 1_000_000: clk cycles a code must stay unchanged to count as a press or release (>=1).
- `LEN_W`, clog2(DIGITS+1): width of length fields (3 for DIGITS=4).

- `clk` in 1: system clock.
- `enable` in 1: asynchronous active-low reset.
- `key` in 5: scanner code; 0 or 17..31 = no key.
- `buf_digits` out 4*DIGITS: live buffer for display; newest digit in [3:0].
- `buf_len` out LEN_W: digits currently held, 0..DIGITS.
- `entry_valid` out 1: completed entry pending.
- `entry_ready` in 1: consumer accepts the pending entry.
- `entry_data` out 4*DIGITS: latched entry, same layout as buf_digits.
- `entry_len` out LEN_W: length of latched entry.
- `fn_valid` out 1: one-cycle pulse on an A..D press.
- `fn_code` out 2: A=0, B=1, C=2, D=3; held until the next fn press.
- `key_err` out 1: one-cycle pulse on a rejected key.

## Operation
- Key map (code -> meaning): 1,2,3->digits 1,2,3; 5,6,7->4,5,6; 9,10,11->7,8,9; 14->0; 4,8,12,16->fn A,B,C,D; 13 (*)->backspace; 15 (#)->enter.
- Debounce FSM states: IDLE, DEBOUNCE, HELD, RELEASE. `cnt` holds STABLE_CYCLES-1 max.
  - IDLE: key valid -> capture code, cnt=0, go to DEBOUNCE.
  - DEBOUNCE: key == captured and cnt==STABLE_CYCLES-1 -> raise internal accept, go to HELD.
  - DEBOUNCE: key == captured otherwise -> cnt++.
  - DEBOUNCE: key none -> IDLE.
  - DEBOUNCE: key is a different valid code -> recapture, cnt=0.
  - HELD: key none -> RELEASE, cnt=0. A different valid code while HELD stays HELD with no event; a release is required first.
  - RELEASE: key valid (any code) -> HELD.
  - RELEASE: key none and cnt==STABLE_CYCLES-1 -> IDLE.
  - RELEASE: key none otherwise -> cnt++.
- On accept, the action is applied at the same edge:
  - Digit, buf_len<DIGITS: buf = {buf[4*DIGITS-5:0], d}, buf_len+1.
  - Digit, buf_len==DIGITS: key_err; buffer unchanged.
  - Backspace, buf_len>0: buf = {4'h0, buf[4*DIGITS-1:4]}, buf_len-1.
  - Backspace, buf_len==0: key_err.
  - Enter, buf_len>0 and entry_valid=0: entry_data=buf, entry_len=buf_len, entry_valid=1, buffer and buf_len cleared.
  - Enter, buf_len==0 or entry_valid=1: key_err; buffer kept.
  - Fn: fn_valid pulse, fn_code updated; buffer and handshake untouched.
- Digits and backspace keep editing the buffer while entry_valid=1.
- Unused upper digits of buf_digits are always 0.

## Timing
- Reset (enable low, async): FSM IDLE, cnt=0, buf_digits=0, buf_len=0, entry_valid=0, entry_data=0, entry_len=0, fn_valid=0, fn_code=0, key_err=0.
- All outputs are registered.
- First edge sampling a valid code is E0 (IDLE->DEBOUNCE). Accept and its output update occur at edge E0+STABLE_CYCLES if the code is unchanged through that edge.
- Release is complete at the edge where RELEASE has seen no key for STABLE_CYCLES consecutive edges. A new press can start in IDLE at the following edge.
- Exactly one accept per press, regardless of hold length.
- fn_valid and key_err are high for exactly one cycle after the accept edge.
- Handshake:
  - entry_valid rises at the enter accept edge.
  - It falls at the first later edge with entry_ready=1. It is high for at least one cycle even if entry_ready is held high.
  - entry_data and entry_len are stable while entry_valid=1.
- Reset mid-operation aborts any debounce or pending entry. If a key is still held after reset release, it is treated as a new press.

## Test plan
Parameters: STABLE_CYCLES=4, DIGITS=4.
- Code 2 held 10 cycles, then 0 for 10 cycles -> after edge E0+4: buf_digits=16'h0002, buf_len=1; no further change; FSM returns to IDLE.
- Code 6 for 2 cycles, 0 for 1 cycle, 6 for 8 cycles -> exactly one digit 5 accepted (buf_digits=16'h0005, buf_len=1), 4 edges after the second press onset.
- Press 1,2,3,5 then 9 -> buf_digits=16'h1234, buf_len=4, key_err pulse on the 9 press; then press 13 -> buf_digits=16'h0123, buf_len=3.
- Press 1,2,15 with entry_ready=0 -> entry_valid=1, entry_data=16'h0012, entry_len=2, buf cleared. Then press 15 -> key_err, entry unchanged. Then entry_ready=1 for one cycle -> entry_valid=0 after that edge.
- Press 4 then 16 -> fn_valid pulses twice, fn_code=0 then 3; buf_digits and buf_len unchanged. Press 13 with empty buffer -> key_err.
- Assert enable=0 mid-DEBOUNCE with entry_valid=1 -> all outputs 0 immediately. Release reset with code 14 held -> digit 0 accepted 4 edges later, buf_len=1.
